// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares one FIFO write port between NUM_REQ
//   requesters. A granted requester may write up to MAX_BURST words before
//   the grant is released. Every burst is followed by one idle cycle, and
//   arbitration takes exactly one cycle.
//
// Ports
//   w_clk_in      : write-domain clock, rising edge
//   w_reset_in    : synchronous active-high reset
//   req_in        : per-requester write request (bit i = requester i)
//   data_in       : packed write data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   w_full_in     : FIFO full flag; stalls the current burst
//   w_request_out : write strobe to the FIFO pointer logic
//   w_data_out    : word to FIFO memory (zero when not writing)
//   grant_out     : registered one-hot grant (zero when idle)
//   ack_out       : one-hot, marks the cycle a word is accepted
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk_in,
  input  logic                          w_reset_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          w_full_in,
  output logic                          w_request_out,
  output logic [DATA_WIDTH-1:0]         w_data_out,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [NUM_REQ-1:0]            ack_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_WD = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_g;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]    w_pick;
  logic                w_pick_valid;
  logic                w_accept;
  logic                w_last_word;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first set request after last_grant, with wrap-around.
  // Scanning from the farthest candidate to the nearest lets the nearest win.
  always_comb begin
    int v_raw;
    int v_idx;
    w_pick       = '0;
    w_pick_valid = |req_in;
    v_raw        = 0;
    v_idx        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_raw  = int'(r_last_grant) + k;
      v_idx  = (v_raw >= NUM_REQ) ? (v_raw - NUM_REQ) : v_raw;
      w_pick = req_in[v_idx] ? IDX_W'(v_idx) : w_pick;
    end
  end

  // State and datapath registers.
  always_ff @(posedge w_clk_in) begin
    if (w_reset_in) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LAST_IDX;
      r_g          <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_g     <= w_pick;
            r_cnt   <= '0;
            r_grant <= onehot(w_pick);
          end else begin
            r_grant <= '0;
          end
        end
        ST_BURST: begin
          if (w_state_next == ST_IDLE) begin
            r_last_grant <= r_g;
            r_grant      <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  // Next-state logic: leave BURST when the owner drops its request or the
  // final word of the burst is accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_next = w_pick_valid ? ST_BURST : ST_IDLE;
      end
      ST_BURST: begin
        if (!req_in[r_g] || w_last_word) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_BURST;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: the write strobe is gated by reset so nothing is written
  // while reset is held; only the owner's request and data reach the port.
  always_comb begin
    w_accept      = (r_state == ST_BURST) && req_in[r_g] && !w_full_in && !w_reset_in;
    w_last_word   = w_accept && (r_cnt == CNT_LAST_WD);
    w_request_out = w_accept;
    grant_out     = r_grant;
    ack_out       = w_accept ? onehot(r_g) : '0;
    w_data_out    = w_accept ? data_in[int'(r_g)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] data;
  logic             full;
  logic             w_request_out;
  logic [DW-1:0]    w_data_out;
  logic [NR-1:0]    grant_out;
  logic [NR-1:0]    ack_out;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: owner (-1 = nobody), words written, last owner
  int m_owner = -1;
  int m_words = 0;
  int m_last  = NR - 1;

  logic [NR-1:0] e_grant;
  logic [NR-1:0] e_ack;
  logic          e_req;
  logic [DW-1:0] e_data;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .w_clk_in      (clk),
    .w_reset_in    (rst),
    .req_in        (req),
    .data_in       (data),
    .w_full_in     (full),
    .w_request_out (w_request_out),
    .w_data_out    (w_data_out),
    .grant_out     (grant_out),
    .ack_out       (ack_out)
  );

  task automatic model_predict();
    e_grant = '0;
    e_ack   = '0;
    e_data  = '0;
    e_req   = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (!rst && req[m_owner] && !full) begin
        e_req          = 1'b1;
        e_ack[m_owner] = 1'b1;
        e_data         = data[m_owner*DW +: DW];
      end
    end
  endtask

  task automatic model_advance();
    bit acc;
    bit found;
    int c;
    if (rst) begin
      m_owner = -1;
      m_words = 0;
      m_last  = NR - 1;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_words = 0;
        end
      end
    end else begin
      acc = req[m_owner] && !full;
      if (acc) m_words++;
      if (m_words == MB || !req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic settle();
    @(negedge clk);
    model_predict();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    settle();
    advance();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = NR'($urandom);
    full = 1'b0;
    rand_data();
    settle();
    advance();
    for (int c = 0; c < 3; c++) begin
      req = NR'($urandom);
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero cyc %0d: got g=%b a=%b r=%b d=%h, expected all zero",
                 c, grant_out, ack_out, w_request_out, w_data_out);
      end
      advance();
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_rotation();
    logic [NR-1:0] order[$];
    logic [NR-1:0] exp_order [5];
    logic [NR-1:0] prev;
    int acks;
    int idles;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req  = 4'b1111;
    prev = '0;
    acks = 0;
    idles = 0;
    for (int c = 0; c < 25; c++) begin
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL rotation cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      if (grant_out != '0 && prev == '0) order.push_back(grant_out);
      if (ack_out != '0) acks++;
      if (grant_out == '0) idles++;
      prev = grant_out;
      advance();
    end
    n_checks++;
    if (order.size() != 5) begin
      n_fail++;
      $display("FAIL rotation_bursts: got %0d bursts, expected 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (order[i] !== exp_order[i]) begin
          n_fail++;
          $display("FAIL rotation_order[%0d]: got %b, expected %b", i, order[i], exp_order[i]);
        end
      end
    end
    n_checks++;
    if (acks != 20 || idles != 5) begin
      n_fail++;
      $display("FAIL rotation_counts: got acks=%0d idles=%0d, expected acks=20 idles=5", acks, idles);
    end
  endtask

  task automatic test_short_burst();
    logic [NR-1:0] tbl [7];
    int acks2;
    tbl = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
    do_reset();
    acks2 = 0;
    for (int c = 0; c < 7; c++) begin
      req = tbl[c];
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL short_burst cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      if (ack_out[2]) acks2++;
      if (c == 1) begin
        n_checks++;
        if (grant_out !== 4'b0100) begin
          n_fail++;
          $display("FAIL short_burst_grant: got %b, expected 0100", grant_out);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (grant_out !== 4'b0000) begin
          n_fail++;
          $display("FAIL short_burst_drop: got %b, expected 0000", grant_out);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (grant_out !== 4'b1000) begin
          n_fail++;
          $display("FAIL short_burst_next: got %b, expected 1000", grant_out);
        end
      end
      advance();
    end
    n_checks++;
    if (acks2 != 2) begin
      n_fail++;
      $display("FAIL short_burst_acks: got %0d, expected 2", acks2);
    end
  endtask

  task automatic test_stall();
    logic fl [9];
    int acks1;
    int stall_acks;
    fl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    acks1 = 0;
    stall_acks = 0;
    for (int c = 0; c < 9; c++) begin
      req  = (c < 8) ? 4'b0010 : 4'b0000;
      full = fl[c];
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      if (ack_out[1]) acks1++;
      if (fl[c]) begin
        if (ack_out != '0) stall_acks++;
        n_checks++;
        if (grant_out !== 4'b0010) begin
          n_fail++;
          $display("FAIL stall_grant cyc %0d: got %b, expected 0010", c, grant_out);
        end
      end
      advance();
    end
    full = 1'b0;
    n_checks++;
    if (acks1 != 4 || stall_acks != 0) begin
      n_fail++;
      $display("FAIL stall_acks: got acks=%0d stall_acks=%0d, expected 4 and 0", acks1, stall_acks);
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] order[$];
    logic [NR-1:0] prev;
    do_reset();
    prev = '0;
    for (int c = 0; c < 13; c++) begin
      req = (c < 5) ? 4'b0001 : 4'b1001;
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL wrap cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      if (grant_out != '0 && prev == '0) order.push_back(grant_out);
      prev = grant_out;
      advance();
    end
    n_checks++;
    if (order.size() < 3 || order[0] !== 4'b0001 || order[1] !== 4'b1000 || order[2] !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_order: got %0d bursts first=%b, expected 0001,1000,0001",
               order.size(), (order.size() > 0) ? order[0] : 4'b0000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = (c < 3) ? 4'b0100 : 4'b0110;
      rst = (c == 2);
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      if (c == 3 && grant_out !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid_drop: got %b, expected 0000", grant_out);
      end
      if (c == 4 && grant_out !== 4'b0010) begin
        n_fail++;
        $display("FAIL reset_mid_next: got %b, expected 0010", grant_out);
      end
      if (c >= 3) n_checks++;
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = NR'($urandom);
      full = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      rand_data();
      settle();
      n_checks++;
      if ({grant_out, ack_out, w_request_out, w_data_out} !== {e_grant, e_ack, e_req, e_data}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got g=%b a=%b r=%b d=%h, expected g=%b a=%b r=%b d=%h",
                 c, grant_out, ack_out, w_request_out, w_data_out, e_grant, e_ack, e_req, e_data);
      end
      advance();
    end
    rst  = 1'b0;
    full = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    data = '0;
    test_reset();
    test_rotation();
    test_short_burst();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
